// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the arbitrated ALU sequencer: opcode encodings,
// opcode width and the sequencer FSM state type.
package alu_ctrl_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_NOT = 3'b000;
    localparam logic [OPW-1:0] OP_AND = 3'b001;
    localparam logic [OPW-1:0] OP_OR  = 3'b010;
    localparam logic [OPW-1:0] OP_XOR = 3'b011;
    localparam logic [OPW-1:0] OP_ADD = 3'b100;
    localparam logic [OPW-1:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: a, b, op -> c, co, err.
// Build option: define ALU_SUB_EN to make opcode 101 a subtract (co = borrow);
// otherwise 101 is reported as illegal like 110 and 111.
module alu_core
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] c,
    output logic             co,
    output logic             err
);

    logic [WIDTH:0] sum;

    // Decode the opcode; carry is only produced by the arithmetic ops
    always_comb begin
        c   = '0;
        co  = 1'b0;
        err = 1'b0;
        sum = '0;
        case (op)
            OP_NOT: c = ~a;
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                c   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
            end
`ifdef ALU_SUB_EN
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (a < b)
                sum = {1'b0, a} - {1'b0, b};
                c   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
            end
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arb_seq.sv
// Round-robin arbitrated front end for a shared ALU: one operation in flight,
// IDLE -> EXEC -> RESP, result held until the owning requester takes it.
// Build option: ALU_SUB_EN (passed through to alu_core) enables opcode 101.
module alu_arb_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = alu_ctrl_pkg::OPW,
    parameter int unsigned NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*OPW-1:0]   req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_c,
    output logic                  rsp_co,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e state_q, state_d;

    logic [IW-1:0]    ptr_q, owner_q, winner;
    logic             found, accept, exec;
    logic [WIDTH-1:0] a_q, b_q, sel_a, sel_b;
    logic [OPW-1:0]   op_q, sel_op;
    logic [WIDTH-1:0] alu_c, c_q;
    logic             alu_co, alu_err, co_q, err_q;

    // Round-robin search: first valid requester after the last winner
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
                    found  = 1'b1;
                    winner = IW'(i);
                end
            end
        end
    end

    // Route the winner's operands to the capture registers
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == winner) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        exec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    // Gated by rst_n so no grant is visible while reset is held
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (IW'(i) == winner) req_ready[i] = rst_n;
                    end
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                exec    = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                // Only the owner's rsp_ready can release the result
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (IW'(i) == owner_q) begin
                        rsp_valid[i] = 1'b1;
                        if (rsp_ready[i]) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Operand/owner capture on accept, result capture in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q   <= winner;
                owner_q <= winner;
                a_q     <= sel_a;
                b_q     <= sel_b;
                op_q    <= sel_op;
            end
            if (exec) begin
                c_q   <= alu_c;
                co_q  <= alu_co;
                err_q <= alu_err;
            end
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .c  (alu_c),
        .co (alu_co),
        .err(alu_err)
    );

    assign rsp_c   = c_q;
    assign rsp_co  = co_q;
    assign rsp_err = err_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed self-checking bench for alu_arb_seq (WIDTH=4, NREQ=2).
module tb_alu_arb_seq;

    localparam int W  = 4;
    localparam int OW = 3;
    localparam int N  = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*OW-1:0] req_op;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_c;
    logic           rsp_co;
    logic           rsp_err;
    logic           busy;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] c;
        logic       co;
    } vec_t;

    vec_t vecs[6] = '{
        '{4'hF, 4'h1, 3'b100, 4'h0, 1'b1},
        '{4'hA, 4'h0, 3'b000, 4'h5, 1'b0},
        '{4'hC, 4'hA, 3'b001, 4'h8, 1'b0},
        '{4'hC, 4'h3, 3'b010, 4'hF, 1'b0},
        '{4'h6, 4'h3, 3'b011, 4'h5, 1'b0},
        '{4'h9, 4'h9, 3'b100, 4'h2, 1'b1}
    };

    alu_arb_seq #(
        .WIDTH(W),
        .OPW  (OW),
        .NREQ (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_c    (rsp_c),
        .rsp_co   (rsp_co),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Drive one request and wait (bounded) for its grant; returns at the negedge after accept
    task automatic issue(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_a[r*W +: W]   = a;
        req_b[r*W +: W]   = b;
        req_op[r*OW +: OW] = op;
        req_valid[r]      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    // Bounded wait for rsp_valid[r]
    task automatic wait_rsp(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid[r]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume(input int r);
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        #1 rst_n  = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if ({rsp_c, rsp_co, rsp_err} !== 6'b0) $display("FAIL reset_rsp got c=%h co=%b err=%b want 0/0/0", rsp_c, rsp_co, rsp_err); else passed++;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        issue(0, 4'h3, 4'h5, 3'b100, ok);
        checks++; if (!ok) $display("FAIL single_grant got no grant want grant"); else passed++;
        #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL single_early got %b want 00", rsp_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 2'b01) $display("FAIL single_latency got %b want 01", rsp_valid); else passed++;
        checks++; if ({rsp_c, rsp_co, rsp_err} !== {4'h8, 1'b0, 1'b0}) $display("FAIL single_result got c=%h co=%b err=%b want 8/0/0", rsp_c, rsp_co, rsp_err); else passed++;
        consume(0);
        #1;
        checks++; if ({rsp_valid, busy} !== 3'b000) $display("FAIL single_done got rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); else passed++;
    endtask

    task automatic test_ops();
        bit ok;
        for (int k = 0; k < 6; k++) begin
            issue(0, vecs[k].a, vecs[k].b, vecs[k].op, ok);
            wait_rsp(0, ok);
            checks++; if (!ok) $display("FAIL ops%0d_rsp got no rsp_valid want rsp_valid", k); else passed++;
            checks++;
            if ({rsp_c, rsp_co, rsp_err} !== {vecs[k].c, vecs[k].co, 1'b0})
                $display("FAIL ops%0d got c=%h co=%b err=%b want %h/%b/0", k, rsp_c, rsp_co, rsp_err, vecs[k].c, vecs[k].co);
            else passed++;
            consume(0);
        end
    endtask

    task automatic test_round_robin();
        int g[$];
        bit twohot;
        int gv;
        apply_reset();
        req_a     = {4'h4, 4'h1};
        req_b     = {4'h4, 4'h2};
        req_op    = {3'b100, 3'b100};
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        twohot    = 1'b0;
        for (int cyc = 0; cyc < 40 && g.size() < 4; cyc++) begin
            #1;
            if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) twohot = 1'b1;
            if (req_ready == 2'b01) g.push_back(0);
            else if (req_ready == 2'b10) g.push_back(1);
            if (rsp_valid == 2'b01) begin
                checks++; if (rsp_c !== 4'h3) $display("FAIL rr_rsp0 got %h want 3", rsp_c); else passed++;
            end else if (rsp_valid == 2'b10) begin
                checks++; if (rsp_c !== 4'h8) $display("FAIL rr_rsp1 got %h want 8", rsp_c); else passed++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rsp_ready = 2'b00;
        checks++; if (twohot !== 1'b0) $display("FAIL rr_onehot got two-hot want one-hot"); else passed++;
        for (int k = 0; k < 4; k++) begin
            gv = (k < g.size()) ? g[k] : -1;
            checks++; if (gv !== k % 2) $display("FAIL rr_grant%0d got %0d want %0d", k, gv, k % 2); else passed++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        issue(0, 4'h6, 4'h3, 3'b011, ok);
        wait_rsp(0, ok);
        checks++; if (!ok) $display("FAIL bp_rsp got no rsp_valid want rsp_valid"); else passed++;
        req_a[W +: W]   = 4'h1;
        req_b[W +: W]   = 4'h1;
        req_op[OW +: OW] = 3'b100;
        req_valid[1]    = 1'b1;
        rsp_ready       = 2'b10;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 2'b01) $display("FAIL bp_valid%0d got %b want 01", cyc, rsp_valid); else passed++;
            checks++; if (rsp_c !== 4'h5) $display("FAIL bp_c%0d got %h want 5", cyc, rsp_c); else passed++;
            checks++; if (req_ready !== 2'b00) $display("FAIL bp_ready%0d got %b want 00", cyc, req_ready); else passed++;
        end
        req_valid[1] = 1'b0;
        rsp_ready    = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        checks++; if ({rsp_valid, busy} !== 3'b000) $display("FAIL bp_release got rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); else passed++;
    endtask

    task automatic test_illegal();
        bit ok;
        issue(1, 4'h5, 4'h5, 3'b111, ok);
        wait_rsp(1, ok);
        checks++; if ({rsp_c, rsp_co, rsp_err} !== {4'h0, 1'b0, 1'b1}) $display("FAIL ill111 got c=%h co=%b err=%b want 0/0/1", rsp_c, rsp_co, rsp_err); else passed++;
        consume(1);
        issue(1, 4'h2, 4'h3, 3'b101, ok);
        wait_rsp(1, ok);
`ifdef ALU_SUB_EN
        checks++; if ({rsp_c, rsp_co, rsp_err} !== {4'hF, 1'b1, 1'b0}) $display("FAIL sub101 got c=%h co=%b err=%b want F/1/0", rsp_c, rsp_co, rsp_err); else passed++;
`else
        checks++; if ({rsp_c, rsp_co, rsp_err} !== {4'h0, 1'b0, 1'b1}) $display("FAIL sub101 got c=%h co=%b err=%b want 0/0/1", rsp_c, rsp_co, rsp_err); else passed++;
`endif
        consume(1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        issue(0, 4'h5, 4'h5, 3'b100, ok);
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL rmid_exec got busy=%b want 1", busy); else passed++;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if ({busy, rsp_valid, req_ready} !== 5'b0) $display("FAIL rmid_ctrl got busy=%b rsp_valid=%b req_ready=%b want 0", busy, rsp_valid, req_ready); else passed++;
        checks++; if ({rsp_c, rsp_co, rsp_err} !== 6'b0) $display("FAIL rmid_rsp got c=%h co=%b err=%b want 0/0/0", rsp_c, rsp_co, rsp_err); else passed++;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 4'h7, 4'h1, 3'b010, ok);
        checks++; if (!ok) $display("FAIL rmid_grant1 got no grant want grant"); else passed++;
        wait_rsp(1, ok);
        checks++; if ({rsp_c, rsp_err} !== {4'h7, 1'b0}) $display("FAIL rmid_rsp1 got c=%h err=%b want 7/0", rsp_c, rsp_err); else passed++;
        consume(1);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rmid_rotate got %b want 01", req_ready); else passed++;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
